// File: rtl/clock_step_controller.sv
// Panel-driven CPU clock-enable sequencer: cycle step, instruction step, run, breakpoint, halt.
// Optional breakpoint support is compiled in when BREAKPOINT_EN is defined.
module clock_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_nReset,
    input  logic        i_btnStep,
    input  logic        i_swInstrNCycle,
    input  logic        i_swStepNRun,
    input  logic        i_swEnableBreakpoint,
    input  logic [15:0] i_breakpointAddress,
    input  logic        i_instrDone,
    input  logic [15:0] i_nextPc,
    input  logic        i_halt,
    output logic        o_clkEn,
    output logic [2:0]  o_state,
    output logic        o_breakHit
);

    localparam int unsigned CNT_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned IDX_STEP   = 0;
    localparam int unsigned IDX_INSTR  = 1;
    localparam int unsigned IDX_MODE   = 2;
`ifdef BREAKPOINT_EN
    localparam int unsigned IDX_BP     = 3;
    localparam int unsigned NIN        = 4;
`else
    localparam int unsigned NIN        = 3;
`endif

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        CYCLE = 3'd1,
        INSTR = 3'd2,
        RUN   = 3'd3,
        BREAK = 3'd4,
        HALT  = 3'd5
    } stateT;

    logic [NIN-1:0]   raw;
    logic [NIN-1:0]   sync1;
    logic [NIN-1:0]   sync2;
    logic [NIN-1:0]   stable;
    logic [CNT_W-1:0] cnt [NIN];
    logic             stepPrev;
    logic             stepReq;
    logic             stepMode;
    logic             instrMode;
    logic             bpHit;
    stateT            state;

`ifdef BREAKPOINT_EN
    assign raw   = {i_swEnableBreakpoint, i_swStepNRun, i_swInstrNCycle, i_btnStep};
    assign bpHit = i_instrDone & stable[IDX_BP] & (i_nextPc == i_breakpointAddress);
`else
    logic unusedBp;
    assign raw      = {i_swStepNRun, i_swInstrNCycle, i_btnStep};
    assign bpHit    = 1'b0;
    assign unusedBp = ^{i_swEnableBreakpoint, i_breakpointAddress, i_nextPc};
`endif

    assign stepMode  = stable[IDX_MODE];
    assign instrMode = stable[IDX_INSTR];
    assign o_state   = 3'(state);

    // Synchronise and debounce every panel input; any bounce restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < int'(NIN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < int'(NIN); i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle step request on the accepted press edge only.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            stepPrev <= 1'b0;
            stepReq  <= 1'b0;
        end else begin
            stepPrev <= stable[IDX_STEP];
            stepReq  <= stable[IDX_STEP] & ~stepPrev;
        end
    end

    // Sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            state      <= WAIT;
            o_clkEn    <= 1'b0;
            o_breakHit <= 1'b0;
        end else begin
            o_clkEn    <= 1'b0;
            o_breakHit <= 1'b0;
            case (state)
                WAIT: begin
                    if (!stepMode) begin
                        state   <= RUN;
                        o_clkEn <= 1'b1;
                    end else if (stepReq) begin
                        state   <= instrMode ? INSTR : CYCLE;
                        o_clkEn <= 1'b1;
                    end
                end
                CYCLE: begin
                    state <= i_halt ? HALT : WAIT;
                end
                INSTR: begin
                    if (i_halt) begin
                        state <= HALT;
                    end else if (i_instrDone) begin
                        state <= WAIT;
                    end else begin
                        o_clkEn <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        state <= HALT;
                    end else if (bpHit) begin
                        state      <= BREAK;
                        o_breakHit <= 1'b1;
                    end else if (stepMode) begin
                        state <= WAIT;
                    end else begin
                        o_clkEn <= 1'b1;
                    end
                end
                BREAK: begin
                    if (stepMode) begin
                        state <= WAIT;
                    end else if (stepReq) begin
                        state   <= RUN;
                        o_clkEn <= 1'b1;
                    end else begin
                        o_breakHit <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed test-plan scenarios plus randomized panel/datapath activity, all checked
// every cycle against a behavioural model built from the timing and mode rules.
module tb_clock_step_controller;

    localparam int D = 4;
`ifdef BREAKPOINT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk;
    logic        nReset;
    logic        btnStep;
    logic        swInstrNCycle;
    logic        swStepNRun;
    logic        swEnableBreakpoint;
    logic [15:0] breakpointAddress;
    logic        instrDone;
    logic [15:0] nextPc;
    logic        halt;
    logic        clkEn;
    logic [2:0]  state;
    logic        breakHit;

    clock_step_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .i_clk               (clk),
        .i_nReset            (nReset),
        .i_btnStep           (btnStep),
        .i_swInstrNCycle     (swInstrNCycle),
        .i_swStepNRun        (swStepNRun),
        .i_swEnableBreakpoint(swEnableBreakpoint),
        .i_breakpointAddress (breakpointAddress),
        .i_instrDone         (instrDone),
        .i_nextPc            (nextPc),
        .i_halt              (halt),
        .o_clkEn             (clkEn),
        .o_state             (state),
        .o_breakHit          (breakHit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nChecks = 0;
    int unsigned nFails  = 0;

    // Model: raw inputs reach the debouncer two edges late; an accepted value flips once
    // the delayed input has disagreed with it for D edges since they last agreed.
    int          edgeNo = 0;
    int          lastAgree [4];
    logic [3:0]  rawHist [$];
    logic [3:0]  mAcc;
    bit          mAccStepOld;
    bit          mStepReq;
    int          mState;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int modelNext(input int s, input bit stepMode, input bit instrMode,
                                     input bit arm, input bit req, input bit done,
                                     input logic [15:0] pc, input logic [15:0] bpA,
                                     input bit hlt);
        bit enabled;
        enabled = (s >= 1) && (s <= 3);
        if (s == 5) return 5;
        if (enabled && hlt) return 5;
        if (BP && s == 3 && done && arm && pc == bpA) return 4;
        case (s)
            1: return 0;
            2: return done ? 0 : 2;
            3: return stepMode ? 0 : 3;
            0: return !stepMode ? 3 : (req ? (instrMode ? 2 : 1) : 0);
            4: return stepMode ? 0 : (req ? 3 : 4);
            default: return 0;
        endcase
    endfunction

    // Advance one clock, update the model from pre-edge inputs, compare all outputs.
    task automatic step();
        logic [3:0]  rawNow;
        logic [3:0]  syncVec;
        bit          rst;
        bit          done;
        bit          hlt;
        logic [15:0] pc;
        int          nxt;
        rawNow = {swEnableBreakpoint, swStepNRun, swInstrNCycle, btnStep};
        rst    = !nReset;
        done   = instrDone;
        hlt    = halt;
        pc     = nextPc;
        @(posedge clk);
        #1;
        edgeNo++;
        if (rst) begin
            mState      = 0;
            mAcc        = '0;
            mAccStepOld = 1'b0;
            mStepReq    = 1'b0;
            rawHist     = {4'b0, 4'b0};
            for (int i = 0; i < 4; i++) lastAgree[i] = edgeNo;
        end else begin
            nxt         = modelNext(mState, mAcc[2], mAcc[1], mAcc[3], mStepReq, done, pc,
                                    breakpointAddress, hlt);
            mStepReq    = mAcc[0] && !mAccStepOld;
            mAccStepOld = mAcc[0];
            syncVec     = rawHist.pop_front();
            rawHist.push_back(rawNow);
            for (int i = 0; i < 4; i++) begin
                if (syncVec[i] == mAcc[i]) begin
                    lastAgree[i] = edgeNo;
                end else if (edgeNo - lastAgree[i] >= D) begin
                    mAcc[i]      = syncVec[i];
                    lastAgree[i] = edgeNo;
                end
            end
            mState = nxt;
        end
        check("state", 32'(state), 32'(mState));
        check("clkEn", 32'(clkEn), 32'((mState >= 1) && (mState <= 3)));
        check("breakHit", 32'(breakHit), 32'(mState == 4));
    endtask

    task automatic steps(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (clkEn) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    initial begin
        int pulses;
        int first;
        int p2;
        int f2;
        int enCount;

        nReset             = 1'b0;
        btnStep            = 1'b0;
        swInstrNCycle      = 1'b0;
        swStepNRun         = 1'b0;
        swEnableBreakpoint = 1'b0;
        breakpointAddress  = 16'h0028;
        instrDone          = 1'b0;
        nextPc             = 16'h0010;
        halt               = 1'b0;
        mAcc               = '0;
        rawHist            = {4'b0, 4'b0};
        for (int i = 0; i < 4; i++) lastAgree[i] = 0;

        steps(3, pulses, first);
        check("reset_state", 32'(state), 32'd0);
        check("reset_clkEn", 32'(clkEn), 32'd0);
        check("reset_breakHit", 32'(breakHit), 32'd0);

        // Cycle-step mode: one clean press gives one enable, 8 cycles after the press.
        swStepNRun = 1'b1;
        nReset     = 1'b1;
        steps(15, pulses, first);
        check("idle_wait", 32'(state), 32'd0);
        btnStep = 1'b1;
        steps(20, pulses, first);
        check("clean_press_pulses", 32'(pulses), 32'd1);
        check("clean_press_latency", 32'(first), 32'd8);
        check("clean_press_back_wait", 32'(state), 32'd0);
        btnStep = 1'b0;
        steps(12, pulses, first);
        check("clean_release_pulses", 32'(pulses), 32'd0);

        // Bouncing press then steady, bouncing release then steady.
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            btnStep = ((k >> 1) & 1) == 0;
            steps(1, p2, f2);
            pulses += p2;
        end
        btnStep = 1'b1;
        steps(15, p2, f2);
        check("bounce_press_pulses", 32'(pulses + p2), 32'd1);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            btnStep = ((k >> 1) & 1) != 0;
            steps(1, p2, f2);
            pulses += p2;
        end
        btnStep = 1'b0;
        steps(15, p2, f2);
        check("bounce_release_pulses", 32'(pulses + p2), 32'd0);

        // Instruction step: instrDone on every 4th enable -> 4 enables then WAIT.
        swInstrNCycle = 1'b1;
        steps(10, pulses, first);
        btnStep = 1'b1;
        enCount = 0;
        for (int k = 0; k < 30; k++) begin
            if (clkEn) begin
                instrDone = (enCount % 4) == 3;
                enCount++;
            end else begin
                instrDone = 1'b0;
            end
            step();
        end
        instrDone = 1'b0;
        check("instr_enables", 32'(enCount), 32'd4);
        check("instr_back_wait", 32'(state), 32'd0);
        btnStep = 1'b0;
        steps(10, pulses, first);

        // Run with breakpoint armed at 0x0028.
        swEnableBreakpoint = 1'b1;
        steps(10, pulses, first);
        swStepNRun = 1'b0;
        steps(10, pulses, first);
        check("run_state", 32'(state), 32'd3);
        nextPc    = 16'h0028;
        instrDone = 1'b1;
        step();
        instrDone = 1'b0;
        nextPc    = 16'h0010;
        check("bp_state", 32'(state), BP ? 32'd4 : 32'd3);
        check("bp_clkEn", 32'(clkEn), BP ? 32'd0 : 32'd1);
        check("bp_breakHit", 32'(breakHit), BP ? 32'd1 : 32'd0);
        steps(5, pulses, first);
        check("bp_hold_pulses", 32'(pulses), BP ? 32'd0 : 32'd5);
        btnStep = 1'b1;
        steps(10, pulses, first);
        check("bp_resume_state", 32'(state), 32'd3);
        check("bp_resume_clkEn", 32'(clkEn), 32'd1);
        btnStep = 1'b0;
        steps(8, pulses, first);

        // Halt from RUN is sticky until reset.
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_state", 32'(state), 32'd5);
        btnStep    = 1'b1;
        swStepNRun = 1'b1;
        steps(12, pulses, first);
        btnStep       = 1'b0;
        swInstrNCycle = 1'b0;
        steps(12, p2, f2);
        check("halt_pulses", 32'(pulses + p2), 32'd0);
        check("halt_sticky", 32'(state), 32'd5);
        nReset = 1'b0;
        step();
        check("halt_reset_state", 32'(state), 32'd0);
        nReset = 1'b1;

        // Randomized panel and datapath activity.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 14) == 0) btnStep = ~btnStep;
            if ($urandom_range(0, 39) == 0) swInstrNCycle = ~swInstrNCycle;
            if ($urandom_range(0, 39) == 0) swStepNRun = ~swStepNRun;
            if ($urandom_range(0, 39) == 0) swEnableBreakpoint = ~swEnableBreakpoint;
            instrDone = $urandom_range(0, 2) == 0;
            nextPc    = ($urandom_range(0, 3) == 0) ? 16'h0028 : 16'($urandom);
            halt      = $urandom_range(0, 799) == 0;
            nReset    = $urandom_range(0, 249) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
